// File: rtl/saturn_phase_sequencer.sv
// ---------------------------------------------------------------------------
// saturn_phase_sequencer : 4-phase instruction ring with reset hold, halt/step
// control and cycle/instruction counters.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module saturn_phase_sequencer #(
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_alu_stall_dec,
  input  logic             i_halt_req,
  input  logic             i_step,
  output logic             o_reset,
  output logic [1:0]       o_phase,
  output logic             o_en_bus_send,
  output logic             o_en_bus_recv,
  output logic             o_en_dec,
  output logic             o_en_alu_dump,
  output logic             o_en_alu_prep,
  output logic             o_en_alu_calc,
  output logic             o_en_alu_init,
  output logic             o_en_alu_save,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_ins_cnt
);

  localparam int                c_HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
  logic [1:0]          r_phase;
  logic [1:0]          w_phase_nxt;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic [CNT_W-1:0]    w_cycle_cnt_nxt;
  logic [CNT_W-1:0]    r_ins_cnt;
  logic [CNT_W-1:0]    w_ins_cnt_nxt;
  logic                w_active;
  logic                w_boundary;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= c_HOLD_INIT;
      r_phase     <= 2'd0;
      r_cycle_cnt <= '0;
      r_ins_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_cycle_cnt <= w_cycle_cnt_nxt;
      r_ins_cnt   <= w_ins_cnt_nxt;
    end
  end

  // A stalled phase 3 is not an instruction boundary; the ring simply keeps turning.
  assign w_boundary = (r_phase == 2'd3) && !i_alu_stall_dec;

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_phase_nxt     = r_phase;
    w_cycle_cnt_nxt = r_cycle_cnt;
    w_ins_cnt_nxt   = r_ins_cnt;
    case (r_state)
      S_HOLD: begin
        w_phase_nxt = 2'd0;
        if (r_hold_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - c_HOLD_W'(1);
        end
      end
      S_RUN, S_STEP: begin
        w_phase_nxt     = r_phase + 2'd1;
        w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
        if (w_boundary) begin
          w_ins_cnt_nxt = r_ins_cnt + CNT_W'(1);
          if ((r_state == S_STEP) || i_halt_req) begin
            w_state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        w_phase_nxt = 2'd0;
        if (!i_halt_req) begin
          w_state_nxt = S_RUN;
        end else if (i_step) begin
          w_state_nxt = S_STEP;
        end
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  assign w_active      = (r_state == S_RUN) || (r_state == S_STEP);
  assign o_reset       = (r_state == S_HOLD);
  assign o_halted      = (r_state == S_HALTED);
  assign o_phase       = r_phase;
  assign o_en_bus_send = w_active && (r_phase == 2'd0);
  assign o_en_bus_recv = w_active && (r_phase == 2'd1);
  assign o_en_dec      = w_active && (r_phase == 2'd2) && !i_alu_stall_dec;
  assign o_en_alu_dump = w_active && (r_phase == 2'd0);
  assign o_en_alu_prep = w_active && (r_phase == 2'd1);
  assign o_en_alu_calc = w_active && (r_phase == 2'd2);
  assign o_en_alu_init = w_active && (r_phase == 2'd3);
  assign o_en_alu_save = w_active && (r_phase == 2'd3);
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_ins_cnt     = r_ins_cnt;

endmodule

`default_nettype wire
